// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, line-control encodings, divider floor.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } rx_state_e;

  typedef enum logic [1:0] {
    PS_EVEN   = 2'b00,
    PS_ODD    = 2'b01,
    PS_STICK0 = 2'b10,
    PS_STICK1 = 2'b11
  } ps_e;

  typedef enum logic [1:0] {
    WLS_5 = 2'b00,
    WLS_6 = 2'b01,
    WLS_7 = 2'b10,
    WLS_8 = 2'b11
  } wls_e;

  localparam int unsigned MIN_DIV = 2;

  // Index of the final data bit for a given word-length code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
    logic [2:0] idx;
    idx = 3'd7;
    case (wls_e'(wls))
      WLS_5: idx = 3'd4;
      WLS_6: idx = 3'd5;
      WLS_7: idx = 3'd6;
      WLS_8: idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every max(div_i,2) clocks while enabled.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] term_c;
  logic                 tick_q;

  always_comb begin
    term_c = div_i - DIV_WIDTH'(1);
    if (div_i < DIV_WIDTH'(MIN_DIV)) term_c = DIV_WIDTH'(MIN_DIV - 1);
  end

  // >= keeps the counter bounded if the divisor shrinks mid-count
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clr_i || !en_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q >= term_c) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + DIV_WIDTH'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled majority-vote deserialiser with error flags,
// overrun detection, idle timeout and a valid/ready character output.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned TIMEOUT_BITS = 40,
  parameter int unsigned TO_CNT_WIDTH = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [1:0]           wls_i,
  input  logic                 pen_i,
  input  logic [1:0]           ps_i,
  input  logic                 stb_i,
  input  logic                 rx_i,
  output logic [7:0]           data_o,
  output logic                 pe_o,
  output logic                 fe_o,
  output logic                 brk_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 ovr_o,
  output logic                 timeout_o,
  output logic                 busy_o
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] SAMP0  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SAMP1  = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] DECIDE = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [TO_CNT_WIDTH-1:0] TO_LIMIT = TO_CNT_WIDTH'(TIMEOUT_BITS);

  logic sync1_q, sync2_q, sync3_q;
  rx_state_e state_q, state_d;
  logic [OS_W-1:0] os_q, os_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic pe_q, pe_d, fe_q, fe_d, brk_q, brk_d, zeros_q, zeros_d;
  logic done_q, done_d, armed_q, armed_d, timeout_q, timeout_d;
  logic [TO_CNT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic busy_q, valid_q, ovr_q;
  logic [7:0] data_q;
  logic pe_out_q, fe_out_q, brk_out_q;

  logic fall_c, start_c, tick_c, maj_c, decide_c, bit_end_c, par_exp_c;

  assign fall_c    = sync3_q & ~sync2_q;
  assign start_c   = en_i && (state_q == S_IDLE) && fall_c;
  assign maj_c     = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
  assign decide_c  = tick_c && (os_q == DECIDE);
  assign bit_end_c = tick_c && (os_q == LAST);

  // Tick runs during a frame, and free-runs in IDLE while the timeout is armed
  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (start_c || !en_i),
    .en_i    (en_i && ((state_q != S_IDLE) || armed_q)),
    .div_i   (div_i),
    .tick_o  (tick_c)
  );

  always_comb begin
    par_exp_c = 1'b0;
    case (ps_e'(ps_i))
      PS_EVEN:   par_exp_c = ^shift_q;
      PS_ODD:    par_exp_c = ~^shift_q;
      PS_STICK0: par_exp_c = 1'b0;
      PS_STICK1: par_exp_c = 1'b1;
      default:   par_exp_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    samp_d   = samp_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    brk_d    = brk_q;
    zeros_d  = zeros_q;
    done_d   = 1'b0;
    armed_d  = armed_q;
    to_cnt_d = to_cnt_q;

    if (tick_c) os_d = (os_q == LAST) ? '0 : os_q + OS_W'(1);
    if (tick_c && (os_q == SAMP0)) samp_d[0] = sync2_q;
    if (tick_c && (os_q == SAMP1)) samp_d[1] = sync2_q;

    if ((state_q == S_IDLE) && armed_q && bit_end_c && (to_cnt_q != TO_LIMIT))
      to_cnt_d = to_cnt_q + TO_CNT_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d  = S_START;
          os_d     = '0;
          shift_d  = '0;
          idx_d    = '0;
          pe_d     = 1'b0;
          fe_d     = 1'b0;
          brk_d    = 1'b0;
          zeros_d  = 1'b1;
          armed_d  = 1'b0;
          to_cnt_d = '0;
        end
      end
      S_START: begin
        if (decide_c && maj_c) begin
          state_d = S_IDLE;
          os_d    = '0;
        end else if (bit_end_c) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (decide_c) begin
          shift_d[idx_q] = maj_c;
          zeros_d        = zeros_q & ~maj_c;
        end
        if (bit_end_c) begin
          if (idx_q == last_bit_idx(wls_i)) state_d = pen_i ? S_PARITY : S_STOP1;
          else idx_d = idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (decide_c) begin
          pe_d    = maj_c ^ par_exp_c;
          zeros_d = zeros_q & ~maj_c;
        end
        if (bit_end_c) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (decide_c) begin
          fe_d  = ~maj_c;
          brk_d = zeros_q & ~maj_c;
          if (!stb_i) begin
            state_d  = S_IDLE;
            os_d     = '0;
            done_d   = 1'b1;
            armed_d  = 1'b1;
            to_cnt_d = '0;
          end
        end else if (bit_end_c && stb_i) begin
          state_d = S_STOP2;
        end
      end
      S_STOP2: begin
        if (decide_c) begin
          fe_d     = fe_q | ~maj_c;
          state_d  = S_IDLE;
          os_d     = '0;
          done_d   = 1'b1;
          armed_d  = 1'b1;
          to_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable aborts any partial character and disarms the timeout
    if (!en_i) begin
      state_d  = S_IDLE;
      os_d     = '0;
      idx_d    = '0;
      done_d   = 1'b0;
      armed_d  = 1'b0;
      to_cnt_d = '0;
    end

    timeout_d = armed_d && (to_cnt_d == TO_LIMIT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sync3_q   <= 1'b1;
      state_q   <= S_IDLE;
      os_q      <= '0;
      samp_q    <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      brk_q     <= 1'b0;
      zeros_q   <= 1'b0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      state_q   <= state_d;
      os_q      <= os_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      brk_q     <= brk_d;
      zeros_q   <= zeros_d;
      done_q    <= done_d;
      armed_q   <= armed_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // Output holding register: a completion while still full and not accepted is dropped
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q    <= '0;
      pe_out_q  <= 1'b0;
      fe_out_q  <= 1'b0;
      brk_out_q <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || ready_i) begin
          data_q    <= shift_q;
          pe_out_q  <= pe_q;
          fe_out_q  <= fe_q;
          brk_out_q <= brk_q;
          valid_q   <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign pe_o      = pe_out_q;
  assign fe_o      = fe_out_q;
  assign brk_o     = brk_out_q;
  assign valid_o   = valid_q;
  assign ovr_o     = ovr_q;
  assign timeout_o = timeout_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: frame-level model feeds an expected-character
// queue that is checked on every accepted character, plus hand-computed pins.
module tb_uart_rx_engine;

  localparam int BIT = 32;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i, en_i, pen_i, stb_i, rx_i, ready_i;
  logic [15:0] div_i;
  logic [1:0]  wls_i, ps_i;
  logic [7:0]  data_o;
  logic        pe_o, fe_o, brk_o, valid_o, ovr_o, timeout_o, busy_o;

  exp_t exp_q[$];
  exp_t got;
  int checks = 0, errors = 0;
  int cyc = 0, n_pop = 0, n_rise = 0, ovr_seen = 0, exp_ovr = 0;
  int rise_cyc = 0, pop_cyc = 0, fall_cyc = 0;
  logic prev_valid = 1'b0;

  uart_rx_engine dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .div_i(div_i), .wls_i(wls_i),
    .pen_i(pen_i), .ps_i(ps_i), .stb_i(stb_i), .rx_i(rx_i), .data_o(data_o),
    .pe_o(pe_o), .fe_o(fe_o), .brk_o(brk_o), .valid_o(valid_o), .ready_i(ready_i),
    .ovr_o(ovr_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: every accepted character must match the head of the model queue
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (valid_o && !prev_valid) begin
        n_rise++;
        rise_cyc = cyc;
      end
      prev_valid = valid_o;
      if (ovr_o) ovr_seen++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char act=%0h exp=none (cycle %0d)", data_o, cyc);
        end else begin
          got = exp_q.pop_front();
          chk("char_data", 32'(data_o), 32'(got.d));
          chk("char_pe", 32'(pe_o), 32'(got.pe));
          chk("char_fe", 32'(fe_o), 32'(got.fe));
          chk("char_brk", 32'(brk_o), 32'(got.brk));
        end
        n_pop++;
        pop_cyc = cyc;
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT) @(posedge clk_i);
    #1;
  endtask

  // Serialises one frame and predicts the character it must produce
  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic [1:0] ps, input logic bad, input int nstop);
    logic [7:0] m, dm;
    logic par;
    int ones;
    exp_t e;
    m    = 8'hFF >> (8 - nb);
    dm   = d & m;
    ones = $countones(dm);
    case (ps)
      2'd0: par = (ones % 2) == 1;
      2'd1: par = (ones % 2) == 0;
      2'd2: par = 1'b0;
      default: par = 1'b1;
    endcase
    if (bad) par = ~par;
    wls_i = 2'(nb - 5);
    pen_i = pen;
    ps_i  = ps;
    stb_i = (nstop == 2);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(dm[i]);
    if (pen) drive_bit(par);
    e = '{d: dm, pe: bad & pen, fe: 1'b0, brk: 1'b0};
    if (!ready_i && exp_q.size() > 0) exp_ovr++;
    else exp_q.push_back(e);
    for (int i = 0; i < nstop; i++) drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n0, o0, eo0, to_lat;
    exp_t eb;
    rst_n_i = 1'b0; en_i = 1'b1; div_i = 16'd2; wls_i = 2'b11; pen_i = 1'b0;
    ps_i = 2'b00; stb_i = 1'b0; rx_i = 1'b1; ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    chk("rst_flags", 32'({pe_o, fe_o, brk_o, ovr_o}), 32'h0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    drive_bit(1'b1); drive_bit(1'b1);

    // 8N1 0xA5 held un-accepted: latency and literal pins
    ready_i = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 2'd0, 1'b0, 1);
    lat = rise_cyc - fall_cyc;
    chk("a5_latency_in_window", 32'(lat >= 300 && lat <= 325), 32'h1);
    chk("a5_valid", 32'(valid_o), 32'h1);
    chk("a5_data_lit", 32'(data_o), 32'hA5);
    chk("a5_flags_lit", 32'({pe_o, fe_o, brk_o}), 32'h0);
    ready_i = 1'b1;
    drive_bit(1'b1);

    // 7E1 0x35 with wrong parity bit
    ready_i = 1'b0;
    send_frame(8'h35, 7, 1'b1, 2'd0, 1'b1, 1);
    chk("7e1_data_lit", 32'(data_o), 32'h35);
    chk("7e1_pe_lit", 32'(pe_o), 32'h1);
    chk("7e1_fe_lit", 32'(fe_o), 32'h0);
    ready_i = 1'b1;
    drive_bit(1'b1);

    // 5O2 and 6-bit stick-1 frames with correct parity
    send_frame(8'h13, 5, 1'b1, 2'd1, 1'b0, 2);
    send_frame(8'h2A, 6, 1'b1, 2'd3, 1'b0, 1);
    send_frame(8'hC4, 8, 1'b1, 2'd2, 1'b1, 2);

    // Glitch shorter than half a bit is rejected
    n0 = n_rise;
    wls_i = 2'b11; pen_i = 1'b0; stb_i = 1'b0;
    rx_i = 1'b0;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    chk("glitch_busy_high", 32'(busy_o), 32'h1);
    @(posedge clk_i); #1;
    rx_i = 1'b1;
    repeat (40) @(posedge clk_i);
    @(negedge clk_i);
    chk("glitch_busy_low", 32'(busy_o), 32'h0);
    chk("glitch_no_char", 32'(n_rise - n0), 32'h0);
    @(posedge clk_i); #1;
    drive_bit(1'b1);

    // Disable mid-character discards it
    n0 = n_rise;
    rx_i = 1'b0;
    repeat (100) @(posedge clk_i);
    #1 en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("dis_busy_low", 32'(busy_o), 32'h0);
    @(posedge clk_i); #1;
    rx_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1 en_i = 1'b1;
    drive_bit(1'b1); drive_bit(1'b1);
    chk("dis_no_char", 32'(n_rise - n0), 32'h0);

    // Break: line low for 20 bit periods gives exactly one character
    n0 = n_pop;
    eb = '{d: 8'h00, pe: 1'b0, fe: 1'b1, brk: 1'b1};
    exp_q.push_back(eb);
    rx_i = 1'b0;
    repeat (20 * BIT) @(posedge clk_i);
    #1;
    drive_bit(1'b1); drive_bit(1'b1);
    chk("brk_one_char", 32'(n_pop - n0), 32'h1);
    send_frame(8'h55, 8, 1'b0, 2'd0, 1'b0, 1);

    // Overrun: second character dropped while the first waits
    o0 = ovr_seen; eo0 = exp_ovr;
    ready_i = 1'b0;
    send_frame(8'h11, 8, 1'b0, 2'd0, 1'b0, 1);
    send_frame(8'h22, 8, 1'b0, 2'd0, 1'b0, 1);
    chk("ovr_data_lit", 32'(data_o), 32'h11);
    chk("ovr_pulse_lit", 32'(ovr_seen - o0), 32'h1);
    chk("ovr_model", 32'(ovr_seen - o0), 32'(exp_ovr - eo0));
    ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("ovr_valid_drop", 32'(valid_o), 32'h0);
    @(posedge clk_i); #1;

    // Idle timeout after 0x5A
    send_frame(8'h5A, 8, 1'b0, 2'd0, 1'b0, 1);
    chk("to_not_early", 32'(timeout_o), 32'h0);
    for (int i = 0; i < 3000 && !timeout_o; i++) @(negedge clk_i);
    chk("to_rise", 32'(timeout_o), 32'h1);
    to_lat = cyc - pop_cyc;
    chk("to_latency_in_window", 32'(to_lat >= 1240 && to_lat <= 1320), 32'h1);
    repeat (200) @(negedge clk_i);
    chk("to_saturated", 32'(timeout_o), 32'h1);
    @(posedge clk_i); #1;
    fork
      send_frame(8'h3C, 8, 1'b0, 2'd0, 1'b0, 1);
      begin
        repeat (8) @(posedge clk_i);
        @(negedge clk_i);
        chk("to_clear_on_start", 32'(timeout_o), 32'h0);
      end
    join

    drive_bit(1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("ovr_total", 32'(ovr_seen), 32'(exp_ovr));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
